uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 87 ++++++++
 tb/tb_uart_rx_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures each byte on the
// receiver's done pulse into a circular FIFO and presents the oldest byte
// first-word-fall-through. Tracks occupancy, almost-full and a sticky
// overrun flag for bytes dropped while the buffer was full.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            din,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_COUNT   = (DEPTH_LOG2 + 1)'(AF_LEVEL);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  overrun_reg, overrun_next;
  logic                  wr_acc, rd_acc, drop;

  // Flags come straight from the registered count so they move together.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == FULL_COUNT);
  assign almost_full = (count_reg >= AF_COUNT);
  assign count       = count_reg;
  assign overrun     = overrun_reg;

  // Head byte is read combinationally from the array; forced to zero when empty.
  assign dout = empty ? 8'h00 : mem[rd_ptr_reg];

  // Acceptance decisions and next-state values for pointers, count and overrun.
  always_comb begin
    rd_acc       = rd & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    wr_acc       = rx_done_tick & (~full | rd_acc);
    drop         = rx_done_tick & ~wr_acc;
    wr_ptr_next  = wr_acc ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next  = rd_acc ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next   = count_reg;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // A new drop takes priority over a clear request in the same cycle.
    overrun_next = overrun_reg;
    if (drop)
      overrun_next = 1'b1;
    else if (clr_ovf)
      overrun_next = 1'b0;
  end

  // Storage write; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr_reg] <= din;
  end

  // Pointer, occupancy and overrun registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based FIFO model predicts
// acceptance, occupancy, flags and read data; a separate monitor compares
// every popped byte against the expected-read queue.
module tb_uart_rx_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int AF_LEVEL   = 12;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                rx_done_tick = 1'b0;
  logic [7:0]          din = 8'h00;
  logic                rd = 1'b0;
  logic                clr_ovf = 1'b0;
  logic [7:0]          dout;
  logic                empty, full, almost_full, overrun;
  logic [DEPTH_LOG2:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];     // model contents, oldest first
  logic [7:0] exp_q[$];  // bytes the consumer is expected to pop
  bit         model_ovf = 1'b0;

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
    .rd(rd), .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
    chk("overrun", 32'(overrun), 32'(model_ovf));
    chk("dout_head", 32'(dout), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit rd_ok, wr_ok;
    rx_done_tick = w; din = d; rd = r; clr_ovf = c;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(mq[0]);
    @(posedge clk);
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    if (w && !wr_ok) model_ovf = 1'b1;
    else if (c) model_ovf = 1'b0;
    #1;
    rx_done_tick = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    check_state();
    $display("txn w=%0b d=%02h r=%0b c=%0b -> count=%0d dout=%02h ovf=%0b",
             w, d, r, c, count, dout, overrun);
  endtask

  // Reset with random same-cycle activity, all of which must be discarded.
  task automatic do_reset();
    reset = 1'b1;
    rx_done_tick = 1'($urandom_range(0, 1));
    din = 8'($urandom);
    rd = 1'($urandom_range(0, 1));
    clr_ovf = 1'b0;
    @(posedge clk);
    mq.delete();
    model_ovf = 1'b0;
    #1;
    reset = 1'b0; rx_done_tick = 1'b0; rd = 1'b0;
    check_state();
    $display("txn reset -> count=%0d empty=%0b", count, empty);
  endtask

  task automatic wr_gap(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: whenever the DUT presents a byte that is being popped, compare it.
  always @(negedge clk) begin
    if (!reset && rd && !empty) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data actual=%02h required=none (unexpected pop) at %0t", dout, $time);
      end else begin
        chk("rd_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] b;
    int rdp;
    do_reset();

    // Idle and reads while empty.
    cycle(0, 8'h00, 0, 0);
    repeat (3) cycle(0, 8'h00, 1, 0);

    // Three bytes in, three out.
    wr_gap(8'hA5); wr_gap(8'h3C); wr_gap(8'hFF);
    repeat (3) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Fill to full, drop one, drain, then clear overrun.
    for (int i = 0; i < 16; i++) wr_gap(8'(i));
    wr_gap(8'h55);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0);

    // Full with simultaneous write and read.
    do_reset();
    for (int i = 0; i < 16; i++) wr_gap(8'(8'h20 + i));
    cycle(1, 8'h77, 1, 0);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);

    // Wrap-around at low occupancy.
    wr_gap(8'hC0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 0);
      if (i % 3 == 0) cycle(1, 8'(8'h80 + i), 1, 0);
      cycle(0, 8'h00, 1, 0);
    end
    repeat (4) cycle(0, 8'h00, 1, 0);

    // Mid-stream reset at count 5.
    for (int i = 0; i < 5; i++) wr_gap(8'(8'hD0 + i));
    do_reset();
    wr_gap(8'h9E);
    cycle(0, 8'h00, 1, 0);

    // Randomized traffic with phases that favour filling, balance and draining.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rdp = ((i / 300) % 3 == 0) ? 10 : (((i / 300) % 3 == 1) ? 50 : 85);
        b = 8'($urandom);
        cycle(($urandom_range(0, 99) < 60), b, ($urandom_range(0, 99) < rdp),
              ($urandom_range(0, 99) < 5));
      end
    end

    repeat (20) cycle(0, 8'h00, 1, 0);
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
